// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - sample-stream input and frame output bundle for tdm_demux4
interface tdm_demux4_if #(
    parameter int WIDTH = 1
) ();
    logic               in_valid;
    logic               in_sync;
    logic [WIDTH-1:0]   in_data;
    logic [4*WIDTH-1:0] out_lanes;
    logic               out_valid;
    logic [1:0]         sel;
    logic               locked;
    logic               frame_err;

    modport master (
        output in_valid, in_sync, in_data,
        input  out_lanes, out_valid, sel, locked, frame_err
    );

    modport slave (
        input  in_valid, in_sync, in_data,
        output out_lanes, out_valid, sel, locked, frame_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 1:4 time-division demux, publishes each complete frame as a parallel word
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);
    typedef enum logic {HUNT, RUN} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic                 locked_q, locked_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic [4*WIDTH-1:0]   out_lanes_q, out_lanes_d;
    // Slot 3 is never staged: it goes straight to out_lanes on publish.
    logic [3*WIDTH-1:0]   staging_q, staging_d;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        locked_d    = locked_q;
        out_lanes_d = out_lanes_q;
        staging_d   = staging_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.in_sync) begin
                        staging_d[WIDTH-1:0] = bus.in_data;
                        sel_d                = 2'd1;
                        state_d              = RUN;
                        locked_d             = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.in_sync) begin
                        // An early sync restarts the frame rather than dropping lock.
                        frame_err_d          = (sel_q != 2'd0);
                        staging_d[WIDTH-1:0] = bus.in_data;
                        sel_d                = 2'd1;
                    end else if (sel_q == 2'd0) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        locked_d    = 1'b0;
                        sel_d       = 2'd0;
                    end else if (sel_q == 2'd3) begin
                        out_lanes_d = {bus.in_data, staging_q};
                        out_valid_d = 1'b1;
                        sel_d       = 2'd0;
                    end else begin
                        staging_d[int'(sel_q)*WIDTH +: WIDTH] = bus.in_data;
                        sel_d = sel_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sel_q       <= 2'd0;
            locked_q    <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            out_lanes_q <= '0;
            staging_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            locked_q    <= locked_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            out_lanes_q <= out_lanes_d;
            staging_q   <= staging_d;
        end
    end

    assign bus.out_lanes = out_lanes_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.locked    = locked_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 with directed frames
module tb_tdm_demux4;
    localparam int EV_NONE = 0;
    localparam int EV_PUB  = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int       kind;
        int       cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_bad;
    ev_t  evq[$];

    logic [3:0] exp_lanes;
    logic [1:0] exp_sel;
    logic       exp_locked;

    tdm_demux4_if #(.WIDTH(1)) bus ();

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares held outputs every cycle and pops the scoreboard on each pulse.
    always @(negedge clk) begin
        int act_kind;
        ev_t e;
        chk("out_lanes", 32'(bus.out_lanes), 32'(exp_lanes));
        chk("sel", 32'(bus.sel), 32'(exp_sel));
        chk("locked", 32'(bus.locked), 32'(exp_locked));
        act_kind = (bus.out_valid ? EV_PUB : 0) + (bus.frame_err ? EV_ERR : 0);
        if (act_kind != EV_NONE) begin
            if (evq.size() == 0) begin
                chk("unexpected_pulse", 32'(act_kind), 32'(EV_NONE));
            end else begin
                e = evq.pop_front();
                chk("pulse_kind", 32'(act_kind), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
            e = evq.pop_front();
            chk("missing_pulse", 32'(act_kind), 32'(e.kind));
        end
    end

    task automatic v(input logic vd, input logic sy, input logic dt,
                     input logic [1:0] esel, input logic elk,
                     input int ev, input logic [3:0] elanes);
        ev_t e;
        @(negedge clk);
        #1;
        bus.in_valid = vd;
        bus.in_sync  = sy;
        bus.in_data  = dt;
        if (ev != EV_NONE) begin
            e.kind = ev;
            e.cyc  = cyc + 1;
            evq.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_sel    = esel;
        exp_locked = elk;
        if (ev == EV_PUB) exp_lanes = elanes;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_sync  = 1'($urandom_range(0, 1));
            bus.in_data  = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
    endtask

    initial begin
        cyc          = 0;
        n_vec        = 0;
        n_bad        = 0;
        exp_lanes    = 4'b0000;
        exp_sel      = 2'd0;
        exp_locked   = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 1'b0;

        repeat (6) begin
            @(negedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sync  = 1'($urandom_range(0, 1));
            bus.in_data  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        idle(5);

        // Unsynced samples in HUNT are silently dropped.
        v(1, 0, 1, 2'd0, 0, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd0, 0, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 0, EV_NONE, 4'b0000);

        v(1, 1, 0, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 1, EV_PUB,  4'b1010);
        idle(1);

        v(1, 1, 1, 2'd1, 1, EV_NONE, 4'b1010);
        idle(1);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b1010);
        idle(3);
        v(1, 0, 1, 2'd3, 1, EV_NONE, 4'b1010);
        idle(2);
        v(1, 0, 0, 2'd0, 1, EV_PUB,  4'b0111);
        idle(2);

        v(1, 1, 0, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 1, EV_PUB,  4'b1010);
        v(1, 1, 0, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd0, 1, EV_PUB,  4'b0110);

        // Early sync restarts the frame with the sync sample in slot 0.
        v(1, 1, 1, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 1, 1, 2'd1, 1, EV_ERR,  4'b0000);
        v(1, 0, 0, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 1, EV_PUB,  4'b1001);

        // Missing sync drops lock; traffic ignored until the next sync.
        v(1, 0, 1, 2'd0, 0, EV_ERR,  4'b0000);
        v(1, 0, 1, 2'd0, 0, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd0, 0, EV_NONE, 4'b0000);
        idle(1);
        v(1, 0, 1, 2'd0, 0, EV_NONE, 4'b0000);
        v(1, 1, 0, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 0, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 1, EV_PUB,  4'b1100);

        v(1, 1, 1, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b0000);
        @(negedge clk);
        #2;
        bus.in_valid = 1'b1;
        exp_sel      = 2'd0;
        exp_locked   = 1'b0;
        exp_lanes    = 4'b0000;
        rst_n        = 1'b0;
        #1;
        chk("async_rst_sel", 32'(bus.sel), 32'd0);
        chk("async_rst_locked", 32'(bus.locked), 32'd0);
        chk("async_rst_lanes", 32'(bus.out_lanes), 32'd0);
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        idle(1);
        v(1, 1, 0, 2'd1, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd2, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd3, 1, EV_NONE, 4'b0000);
        v(1, 0, 1, 2'd0, 1, EV_PUB,  4'b1110);
        idle(3);

        chk("scoreboard_drained", 32'(evq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end
endmodule
